romulus_round_scheduler: RTL and testbench

//  Sequences the multi-cycle Skinny round function of the protected Romulus datapath.
//  On each accepted start it issues one full TBC call:
//   - one-hot ring enable (enrnd), CLKS_PER_RND clocks per round;
//   - 6-bit LFSR round constant (constant);
//   - round index and last-round flag.

---
 rtl/romulus_round_scheduler.sv | 131 +++++++++++++
 tb/tb_romulus_round_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/romulus_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : romulus_round_scheduler
// Purpose : Drives the Skinny round function of the protected Romulus datapath.
//           Each accepted start issues one TBC call: a one-hot ring enable,
//           an LFSR round constant, a round index and a last-round flag.
//           Define ROMULUS_RDI_STALL_EN to freeze the schedule while rdi_valid=0.
// Revision: 1.0 - initial release
// ============================================================================
module romulus_round_scheduler #(
    parameter int CONSTW       = 6,
    parameter int CLKS_PER_RND = 4,
    parameter int ROUNDS       = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    ready,
    input  logic                    abort,
    input  logic                    rdi_valid,
    output logic [CLKS_PER_RND-1:0] enrnd,
    output logic [CONSTW-1:0]       constant,
    output logic [7:0]              round_cnt,
    output logic                    last_rnd,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0]              LAST_RND   = 8'(ROUNDS - 1);
    localparam logic [CLKS_PER_RND-1:0] RING_FIRST = {{(CLKS_PER_RND-1){1'b0}}, 1'b1};
    localparam logic [CONSTW-1:0]       RC_FIRST   = {{(CONSTW-1){1'b0}}, 1'b1};

    logic [1:0]              state;
    logic [1:0]              next_state;
    logic [CLKS_PER_RND-1:0] ring;
    logic [CONSTW-1:0]       rc;
    logic [7:0]              rnd;
    logic                    stall;
    logic                    advance;
    logic                    rnd_end;
    logic                    call_end;
    logic                    accept;

`ifdef ROMULUS_RDI_STALL_EN
    assign stall = (state == S_RUN) && !rdi_valid;
`else
    logic unused_rdi_valid;
    assign unused_rdi_valid = rdi_valid;
    assign stall            = 1'b0;
`endif

    assign accept   = (state == S_IDLE) && start && !abort;
    assign advance  = (state == S_RUN) && !stall;
    assign rnd_end  = ring[CLKS_PER_RND-1];
    assign call_end = rnd_end && (rnd == LAST_RND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) next_state = S_RUN;
                S_RUN:   if (advance && call_end) next_state = S_DONE;
                S_DONE:  next_state = S_IDLE;
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Ring, constant and round index; the final round leaves rc/rnd at their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring <= '0;
            rc   <= '0;
            rnd  <= '0;
        end else if (abort) begin
            ring <= '0;
            rc   <= '0;
            rnd  <= '0;
        end else if (accept) begin
            ring <= RING_FIRST;
            rc   <= RC_FIRST;
            rnd  <= '0;
        end else if (advance) begin
            if (call_end) begin
                ring <= '0;
            end else if (rnd_end) begin
                ring <= RING_FIRST;
                rnd  <= rnd + 8'd1;
                rc   <= {rc[CONSTW-2:0], rc[CONSTW-1] ^ rc[CONSTW-2] ^ 1'b1};
            end else begin
                ring <= {ring[CLKS_PER_RND-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        last_rnd  = 1'b0;
        enrnd     = '0;
        constant  = rc;
        round_cnt = rnd;
        case (state)
            S_IDLE: ready = 1'b1;
            S_RUN: begin
                busy     = 1'b1;
                last_rnd = (rnd == LAST_RND);
                enrnd    = stall ? '0 : ring;
            end
            S_DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_romulus_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_romulus_round_scheduler
// Purpose : Directed self-checking bench for romulus_round_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_romulus_round_scheduler;

    localparam int CPR = 4;
    localparam int NR  = 40;
    localparam int LAT = NR * CPR;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       rdi_valid = 1'b1;
    logic       ready;
    logic       last_rnd;
    logic       busy;
    logic       done;
    logic [3:0] enrnd;
    logic [5:0] constant;
    logic [7:0] round_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Skinny round constants, rounds 0..39
    logic [5:0] rc_tab [40] = '{
        6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
        6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
        6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
        6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
    };

    // {enrnd, constant, round_cnt, last_rnd, busy, done, ready}
    logic [21:0] obs;
    assign obs = {enrnd, constant, round_cnt, last_rnd, busy, done, ready};

    localparam logic [21:0] IDLE_RESET = {4'h0, 6'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    romulus_round_scheduler #(
        .CONSTW      (6),
        .CLKS_PER_RND(CPR),
        .ROUNDS      (NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ready    (ready),
        .abort    (abort),
        .rdi_valid(rdi_valid),
        .enrnd    (enrnd),
        .constant (constant),
        .round_cnt(round_cnt),
        .last_rnd (last_rnd),
        .busy     (busy),
        .done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (obs !== IDLE_RESET) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", obs, IDLE_RESET);
        end
        #12 rst = 1'b1;
        step();
        vectors++;
        if (obs !== IDLE_RESET) begin
            miscompares++;
            $display("FAIL reset_release: got %h expected %h", obs, IDLE_RESET);
        end
    endtask

    task automatic test_start_pulse();
        logic [21:0] exp;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            exp = {4'(1 << (c % CPR)), rc_tab[c / CPR], 8'(c / CPR),
                   (c / CPR == NR - 1), 1'b1, 1'b0, 1'b0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL start_pulse cycle %0d: got %h expected %h", c, obs, exp);
            end
            step();
        end
        exp = {4'h0, 6'h1A, 8'd39, 1'b0, 1'b0, 1'b1, 1'b0};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL done_cycle_160: got %h expected %h", obs, exp);
        end
        step();
        exp = {4'h0, 6'h1A, 8'd39, 1'b0, 1'b0, 1'b0, 1'b1};
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL ready_cycle_161: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_round_constants();
        logic [5:0] log_rc [40];
        int         last_cycles;
        int         last_round;
        last_cycles = 0;
        last_round  = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            if (c % CPR == CPR - 1) log_rc[c / CPR] = constant;
            if (last_rnd === 1'b1) begin
                last_cycles++;
                last_round = int'(round_cnt);
            end
            step();
        end
        for (int r = 0; r < NR; r++) begin
            vectors++;
            if (log_rc[r] !== rc_tab[r]) begin
                miscompares++;
                $display("FAIL rc_round_%0d: got %h expected %h", r, log_rc[r], rc_tab[r]);
            end
        end
        vectors++;
        if (last_cycles != CPR || last_round != NR - 1) begin
            miscompares++;
            $display("FAIL last_rnd_window: got %0d cycles in round %0d expected %0d cycles in round %0d",
                     last_cycles, last_round, CPR, NR - 1);
        end
        step();
    endtask

    task automatic test_abort();
        int lat;
        int seen_done;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (50) step();
        vectors++;
        if (round_cnt !== 8'd12 || enrnd !== 4'b0100) begin
            miscompares++;
            $display("FAIL abort_precondition: got cnt %0d enrnd %b expected cnt 12 enrnd 0100",
                     round_cnt, enrnd);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if (obs !== IDLE_RESET) begin
            miscompares++;
            $display("FAIL abort_flush: got %h expected %h", obs, IDLE_RESET);
        end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) seen_done++;
            step();
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d done cycles expected 0", seen_done);
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        vectors++;
        if (obs !== IDLE_RESET) begin
            miscompares++;
            $display("FAIL abort_beats_start: got %h expected %h", obs, IDLE_RESET);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 400) begin
            step();
            lat++;
        end
        vectors++;
        if (lat != LAT || constant !== 6'h1A || round_cnt !== 8'd39) begin
            miscompares++;
            $display("FAIL abort_recall: got latency %0d rc %h cnt %0d expected latency %0d rc 1a cnt 39",
                     lat, constant, round_cnt, LAT);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int bad;
        int lat;
        start = 1'b1;
        step();
        bad = 0;
        for (int c = 0; c < LAT; c++) begin
            if (round_cnt !== 8'(c / CPR) || enrnd !== 4'(1 << (c % CPR))) bad++;
            step();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL b2b_no_restart: got %0d bad cycles expected 0", bad);
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done: got done %b busy %b expected done 1 busy 0", done, busy);
        end
        step();
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle_gap: got ready %b done %b busy %b expected 1 0 0", ready, done, busy);
        end
        step();
        vectors++;
        if (enrnd !== 4'b0001 || constant !== 6'h01 || round_cnt !== 8'd0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_start: got enrnd %b rc %h cnt %0d busy %b expected 0001 01 0 1",
                     enrnd, constant, round_cnt, busy);
        end
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 400) begin
            step();
            lat++;
        end
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL b2b_second_latency: got %0d expected %0d", lat, LAT);
        end
        step();
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        #3 rst = 1'b0;
        #1;
        vectors++;
        if (obs !== IDLE_RESET) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs, IDLE_RESET);
        end
        #2 rst = 1'b1;
        step();
        vectors++;
        if (obs !== IDLE_RESET) begin
            miscompares++;
            $display("FAIL async_reset_release: got %h expected %h", obs, IDLE_RESET);
        end
    endtask

`ifdef ROMULUS_RDI_STALL_EN
    task automatic test_stall();
        logic [21:0] exp;
        logic        stalled;
        int          k;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < LAT + 7; c++) begin
            stalled   = (c >= 13 && c < 20);
            rdi_valid = !stalled;
            k = (c < 13) ? c : (stalled ? 13 : c - 7);
            #1;
            exp = {stalled ? 4'h0 : 4'(1 << (k % CPR)), rc_tab[k / CPR], 8'(k / CPR),
                   (k / CPR == NR - 1), 1'b1, 1'b0, 1'b0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL stall cycle %0d: got %h expected %h", c, obs, exp);
            end
            step();
        end
        rdi_valid = 1'b1;
        vectors++;
        if (done !== 1'b1 || constant !== 6'h1A) begin
            miscompares++;
            $display("FAIL stall_done_167: got done %b rc %h expected done 1 rc 1a", done, constant);
        end
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_pulse();
        test_round_constants();
        test_abort();
        test_back_to_back();
        test_async_reset();
`ifdef ROMULUS_RDI_STALL_EN
        test_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
